// File: rtl/basket_controller.sv
// Shopping-basket slot store with add-or-merge, remove-with-compaction and clear.
// Slots stay packed from slot 0; every operation finishes through DONE.
module basket_controller #(
    parameter int DEPTH = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       Add_Pulse,
    input  logic [3:0] ProductID_in,
    input  logic [3:0] ProductQuantity_in,
    input  logic       Remove_Pulse,
    input  logic [2:0] RemoveIndex,
    input  logic       Clear_Pulse,
    input  logic [2:0] RdIndex,
    output logic [3:0] RdProductID,
    output logic [3:0] RdQuantity,
    output logic [3:0] BasketProductNum,
    output logic [6:0] TotalQuantity,
    output logic       Busy,
    output logic       Full,
    output logic       Done_Pulse,
    output logic       Err_Pulse
);

    localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [2:0] {IDLE, SEARCH, APPEND, SHIFT, DONE} state_t;
    typedef struct packed {
        logic [3:0] id;
        logic [3:0] qty;
    } slot_t;

    state_t     state_q, state_d;
    slot_t      slot_q [DEPTH];
    slot_t      slot_d [DEPTH];
    logic [3:0] count_q, count_d;
    logic [6:0] total_q, total_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] add_id_q, add_id_d;
    logic [3:0] add_qty_q, add_qty_d;
    logic       err_q, err_d;

    slot_t      cur;
    slot_t      rd_slot;
    logic [2:0] idx_nx;
    logic [4:0] sum;
    logic [3:0] sat_qty;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        state_d   = state_q;
        slot_d    = slot_q;
        count_d   = count_q;
        total_d   = total_q;
        idx_d     = idx_q;
        add_id_d  = add_id_q;
        add_qty_d = add_qty_q;
        // Add/remove pulses are dropped whenever they cannot start right now.
        err_d     = (state_q != IDLE || Clear_Pulse) ? (Add_Pulse | Remove_Pulse) : 1'b0;

        cur     = slot_q[idx_q[IW-1:0]];
        idx_nx  = idx_q + 3'd1;
        sum     = 5'(cur.qty) + 5'(add_qty_q);
        sat_qty = (sum > 5'd15) ? 4'd15 : sum[3:0];

        if (Clear_Pulse) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
            count_d = '0;
            total_d = '0;
            state_d = DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Add_Pulse) begin
                        err_d = Remove_Pulse;
                        if (ProductQuantity_in == 4'd0) begin
                            state_d = DONE;
                        end else begin
                            add_id_d  = ProductID_in;
                            add_qty_d = ProductQuantity_in;
                            idx_d     = '0;
                            state_d   = (count_q == 4'd0) ? APPEND : SEARCH;
                        end
                    end else if (Remove_Pulse) begin
                        if ({1'b0, RemoveIndex} >= count_q) begin
                            err_d = 1'b1;
                        end else begin
                            total_d = total_q - 7'(slot_q[RemoveIndex[IW-1:0]].qty);
                            idx_d   = RemoveIndex;
                            state_d = SHIFT;
                        end
                    end
                end
                SEARCH: begin
                    if (cur.id == add_id_q) begin
                        slot_d[idx_q[IW-1:0]].qty = sat_qty;
                        total_d = total_q + 7'(sat_qty - cur.qty);
                        state_d = DONE;
                    end else if ({1'b0, idx_q} == count_q - 4'd1) begin
                        state_d = APPEND;
                    end else begin
                        idx_d = idx_nx;
                    end
                end
                APPEND: begin
                    if (count_q < DEPTH_C) begin
                        slot_d[count_q[IW-1:0]] = '{id: add_id_q, qty: add_qty_q};
                        count_d = count_q + 4'd1;
                        total_d = total_q + 7'(add_qty_q);
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    if ({1'b0, idx_q} < count_q - 4'd1) begin
                        slot_d[idx_q[IW-1:0]] = slot_q[idx_nx[IW-1:0]];
                        idx_d = idx_nx;
                    end else begin
                        slot_d[idx_q[IW-1:0]] = '0;
                        count_d = count_q - 4'd1;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state updates use <= only, so every flop samples the same pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            count_q   <= '0;
            total_q   <= '0;
            idx_q     <= '0;
            add_id_q  <= '0;
            add_qty_q <= '0;
            err_q     <= 1'b0;
            // NOTE: slot storage is reset because the read port exposes it directly.
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            total_q   <= total_d;
            idx_q     <= idx_d;
            add_id_q  <= add_id_d;
            add_qty_q <= add_qty_d;
            err_q     <= err_d;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign rd_slot          = ({1'b0, RdIndex} < count_q) ? slot_q[RdIndex[IW-1:0]] : '0;
    assign RdProductID      = rd_slot.id;
    assign RdQuantity       = rd_slot.qty;
    assign BasketProductNum = count_q;
    assign TotalQuantity    = total_q;
    assign Busy             = (state_q != IDLE);
    assign Full             = (count_q == DEPTH_C);
    assign Done_Pulse       = (state_q == DONE);
    assign Err_Pulse        = err_q;

endmodule

// File: tb/tb_basket_controller.sv
// Randomized check of basket_controller against a queue-based basket model,
// plus directed cases for collisions, busy drops, clear mid-shift and reset mid-search.
module tb_basket_controller;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add_p = 1'b0, rem_p = 1'b0, clr_p = 1'b0;
    logic [3:0] pid = '0, pqty = '0;
    logic [2:0] rem_idx = '0, rd_idx = '0;
    logic [3:0] rd_id, rd_qty, num;
    logic [6:0] total;
    logic       busy, full, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    int mq_id[$];
    int mq_qty[$];

    basket_controller #(.DEPTH(DEPTH)) dut (
        .CLOCK_50          (clk),
        .RESET             (rst),
        .Add_Pulse         (add_p),
        .ProductID_in      (pid),
        .ProductQuantity_in(pqty),
        .Remove_Pulse      (rem_p),
        .RemoveIndex       (rem_idx),
        .Clear_Pulse       (clr_p),
        .RdIndex           (rd_idx),
        .RdProductID       (rd_id),
        .RdQuantity        (rd_qty),
        .BasketProductNum  (num),
        .TotalQuantity     (total),
        .Busy              (busy),
        .Full              (full),
        .Done_Pulse        (done),
        .Err_Pulse         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Applies one request set to the model; returns the cycle Done is due (0 = none).
    function automatic void model_op(input bit a, input bit r, input bit c,
                                     input int id, input int q, input int ri,
                                     output int done_lat, output bit exp_err);
        int n = mq_id.size();
        int k = -1;
        done_lat = 0;
        exp_err  = 1'b0;
        if (c) begin
            mq_id.delete();
            mq_qty.delete();
            exp_err  = a | r;
            done_lat = 1;
        end else if (a) begin
            exp_err = r;
            if (q == 0) begin
                done_lat = 1;
            end else begin
                for (int i = 0; i < n; i++) if (k < 0 && mq_id[i] == id) k = i;
                if (k >= 0) begin
                    mq_qty[k] = (mq_qty[k] + q > 15) ? 15 : mq_qty[k] + q;
                    done_lat  = k + 2;
                end else if (n < DEPTH) begin
                    mq_id.push_back(id);
                    mq_qty.push_back(q);
                    done_lat = n + 2;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end else if (r) begin
            if (ri >= n) begin
                exp_err = 1'b1;
            end else begin
                mq_id.delete(ri);
                mq_qty.delete(ri);
                done_lat = n - ri + 1;
            end
        end
    endfunction

    task automatic check_basket(input string tag);
        int tot = 0;
        foreach (mq_qty[i]) tot += mq_qty[i];
        check({tag, "_count"}, num, mq_id.size());
        check({tag, "_total"}, total, tot);
        check({tag, "_full"}, full, (mq_id.size() == DEPTH));
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            check({tag, "_rd_id"}, rd_id, (i < mq_id.size()) ? mq_id[i] : 0);
            check({tag, "_rd_qty"}, rd_qty, (i < mq_qty.size()) ? mq_qty[i] : 0);
        end
    endtask

    task automatic do_op(input string tag, input bit a, input bit r, input bit c,
                         input int id, input int q, input int ri);
        int  exp_done, got_done = 0, n_done = 0;
        bit  exp_err, got_err = 1'b0;
        model_op(a, r, c, id, q, ri, exp_done, exp_err);
        @(negedge clk);
        add_p = a; rem_p = r; clr_p = c;
        pid = 4'(id); pqty = 4'(q); rem_idx = 3'(ri);
        @(negedge clk);
        add_p = 1'b0; rem_p = 1'b0; clr_p = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done) begin n_done++; got_done = cyc; end
            if (err) got_err = 1'b1;
            if (!busy) break;
        end
        check({tag, "_idle"}, busy, 0);
        check({tag, "_done_cnt"}, n_done, (exp_done != 0) ? 1 : 0);
        check({tag, "_done_lat"}, got_done, exp_done);
        check({tag, "_err"}, got_err, exp_err);
        check_basket(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq_id.delete();
        mq_qty.delete();
    endtask

    initial begin
        int dl;
        bit de;
        bit saw_err;

        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check_basket("rst");

        // Empty-basket add, then saturating merge
        do_op("add_first", 1, 0, 0, 3, 2, 0);
        do_op("add_sat", 1, 0, 0, 3, 14, 0);
        check("sat_total", total, 15);

        // Fill to capacity, then one more new ID
        do_op("clr_fill", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) do_op("fill", 1, 0, 0, i, i + 1, 0);
        do_op("add_full", 1, 0, 0, 9, 5, 0);
        check("full_flag", full, 1);
        do_op("add_zero", 1, 0, 0, 4, 0, 0);

        // Remove compaction and out-of-range remove
        do_op("clr_rm", 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) do_op("rm_setup", 1, 0, 0, i, i, 0);
        do_op("rm0", 0, 1, 0, 0, 0, 0);
        check("rm0_total", total, 5);
        do_op("rm5", 0, 1, 0, 0, 0, 5);
        do_op("rm_last", 0, 1, 0, 0, 0, 1);

        // Add and remove in the same cycle: add wins, remove dropped
        do_op("collide", 1, 1, 0, 7, 4, 0);
        do_op("clr_all3", 1, 1, 1, 8, 4, 0);

        // Clear while SHIFT is running
        for (int i = 0; i < 5; i++) do_op("shift_setup", 1, 0, 0, 10 + i, 2, 0);
        @(negedge clk);
        rem_p = 1'b1; rem_idx = 3'd0;
        @(negedge clk);
        rem_p = 1'b0;
        check("shift_busy", busy, 1);
        clr_p = 1'b1;
        @(negedge clk);
        clr_p = 1'b0;
        model_op(0, 0, 1, 0, 0, 0, dl, de);
        check("clr_shift_done", done, 1);
        check("clr_shift_err", err, 0);
        @(negedge clk);
        check("clr_shift_idle", busy, 0);
        check_basket("clr_shift");

        // Add pulse while busy is dropped with an error
        for (int i = 0; i < 4; i++) do_op("busy_setup", 1, 0, 0, 10 + i, 1, 0);
        model_op(1, 0, 0, 5, 1, 0, dl, de);
        @(negedge clk);
        add_p = 1'b1; pid = 4'd5; pqty = 4'd1;
        @(negedge clk);
        add_p = 1'b0;
        @(negedge clk);
        add_p = 1'b1; pid = 4'd9; pqty = 4'd9;
        @(negedge clk);
        add_p = 1'b0;
        check("busy_add_err", err, 1);
        saw_err = 1'b0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
        check("busy_add_idle", busy, 0);
        check_basket("busy_add");

        // Reset in the middle of SEARCH
        @(negedge clk);
        add_p = 1'b1; pid = 4'd6; pqty = 4'd3;
        @(negedge clk);
        add_p = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq_id.delete();
        mq_qty.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (done) saw_err = 1'b1;
        end
        check("mid_rst_no_done", saw_err, 0);
        check_basket("mid_rst");

        // Randomized traffic against the model
        for (int t = 0; t < 250; t++) begin
            int sel = $urandom_range(0, 99);
            int id  = $urandom_range(0, 11);
            int q   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 15);
            int ri  = $urandom_range(0, (mq_id.size() < 7) ? mq_id.size() : 7);
            if (sel < 55)      do_op("rnd_add", 1, 0, 0, id, q, ri);
            else if (sel < 85) do_op("rnd_rm", 0, 1, 0, id, q, ri);
            else if (sel < 89) do_op("rnd_clr", 0, 0, 1, id, q, ri);
            else if (sel < 95) do_op("rnd_ar", 1, 1, 0, id, q, ri);
            else do_op("rnd_mix", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), id, q, ri);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/basket_controller.md
BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of basket slots; legal values are powers of two from 2 to 8.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Add_Pulse, input, 1 bit: one-cycle add request.
REQ-005 SHALL have port ProductID_in, input, 4 bits: product to add, sampled with Add_Pulse.
REQ-006 SHALL have port ProductQuantity_in, input, 4 bits: quantity to add, sampled with Add_Pulse.
REQ-007 SHALL have port Remove_Pulse, input, 1 bit: one-cycle slot-removal request.
REQ-008 SHALL have port RemoveIndex, input, 3 bits: slot to remove, sampled with Remove_Pulse.
REQ-009 SHALL have port Clear_Pulse, input, 1 bit: one-cycle request to empty the basket.
REQ-010 SHALL have port RdIndex, input, 3 bits: asynchronous read address for display.
REQ-011 SHALL have port RdProductID, output, 4 bits: ID in slot RdIndex, combinational.
REQ-012 SHALL have port RdQuantity, output, 4 bits: quantity in slot RdIndex, combinational.
REQ-013 SHALL have port BasketProductNum, output, 4 bits: number of occupied slots, registered.
REQ-014 SHALL have port TotalQuantity, output, 7 bits: sum of all slot quantities, registered.
REQ-015 SHALL have port Busy, output, 1 bit: high while an operation is in progress.
REQ-016 SHALL have port Full, output, 1 bit: high when BasketProductNum equals DEPTH.
REQ-017 SHALL have port Done_Pulse, output, 1 bit: one-cycle pulse when an operation completes.
REQ-018 SHALL have port Err_Pulse, output, 1 bit: one-cycle pulse when a request is rejected or dropped.

Function
REQ-019 SHALL implement FSM states IDLE, SEARCH, APPEND, SHIFT and DONE; Busy is high in every state except IDLE.
REQ-020 SHALL, in IDLE, apply priority Clear_Pulse > Add_Pulse > Remove_Pulse; each lower-priority pulse arriving in the same cycle SHALL be dropped with Err_Pulse.
REQ-021 SHALL, on Clear_Pulse in any state, set count, TotalQuantity and all slots to 0 on the next edge, go to DONE, and abort any operation in progress.
REQ-022 SHALL, on an add with quantity 0, make no change to the basket and go to DONE.
REQ-023 SHALL, on an add with nonzero quantity, latch the ID and quantity and enter SEARCH with scan index 0; if count is 0, enter APPEND instead.
REQ-024 SHALL, in SEARCH, compare one slot per cycle; on an ID match, set qty = min(qty + in, 15), add the applied increment to TotalQuantity, and go to DONE.
REQ-025 SHALL, in SEARCH, go to APPEND when the scan index reaches count-1 with no match.
REQ-026 SHALL, in APPEND, write the ID and quantity to slot[count], increment count and TotalQuantity, and go to DONE when count < DEPTH; otherwise it SHALL assert Err_Pulse, make no change, and go to IDLE.
REQ-027 SHALL, on a remove with RemoveIndex >= count, assert Err_Pulse and stay in IDLE.
REQ-028 SHALL, on a valid remove, subtract slot quantity from TotalQuantity, then in SHIFT copy slot[i+1] to slot[i] one slot per cycle from RemoveIndex to count-2; it SHALL then zero slot[count-1], decrement count, and go to DONE.
REQ-029 SHALL, in DONE, assert Done_Pulse for exactly one cycle and return to IDLE.
REQ-030 SHALL ignore Add_Pulse and Remove_Pulse received while Busy and assert Err_Pulse for each; Clear_Pulse SHALL NOT be ignored while Busy.
REQ-031 SHALL keep occupied slots contiguous from slot 0, unique by ID, and with quantity >= 1.
REQ-032 SHALL return 0 on RdProductID and RdQuantity when RdIndex >= count.
REQ-033 SHALL require the latency of an add that matches slot k to be k+2 cycles from the pulse to Done_Pulse.

Reset
REQ-034 SHALL, with RESET high at an edge, set state IDLE, count 0, TotalQuantity 0, all slots 0, and Busy, Done_Pulse and Err_Pulse to 0; RESET SHALL override every other input, including mid-operation.

Verification
REQ-035 Add (ID 3, qty 2) to an empty basket: SHALL produce count 1, slot0 = (3,2), TotalQuantity 2, and Done_Pulse.
REQ-036 Add (3,2) then (3,14): SHALL leave slot0 qty saturated at 15, TotalQuantity 15, count 1.
REQ-037 Fill 8 distinct IDs, then add a ninth new ID: SHALL assert Err_Pulse, keep Full high, leave count 8 and the basket unchanged.
REQ-038 Basket (1,1)(2,2)(3,3), remove index 0: SHALL produce (2,2)(3,3), count 2, TotalQuantity 5; remove index 5: SHALL assert Err_Pulse.
REQ-039 Add_Pulse and Remove_Pulse in the same cycle: SHALL complete the add and drop the remove with Err_Pulse; Clear_Pulse during SHIFT: SHALL empty the basket and assert Done_Pulse.
REQ-040 RESET asserted during SEARCH: SHALL produce count 0, Busy 0 on the next cycle, and no Done_Pulse.
